aes_inv_key_schedule: RTL and testbench

- Decryption-side companion to the forward AES-128 key expansion.
- Loads the cipher key and runs the forward schedule internally to reach round key 10.
- Then steps the schedule backward one round per consumer request, presenting round keys 10, 9, … 0 in the order the inverse cipher rounds consume them.
- Sits between key load and the inverse round datapath.

---
 rtl/aes_inv_key_schedule.sv | 212 +++++++++++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule.
// Loads a cipher key, runs the forward expansion internally up to round key NR,
// then walks the schedule backward one round per consumer request so the keys
// appear in inverse-cipher order (NR, NR-1, ... 0).
// The S-box is a registered table, so every schedule step is a SUB cycle
// (word presented to the table) followed by an XOR cycle (words updated).
// Optional feature: define AES_INV_KS_DIRECT_LOAD_EN to add the load_last input,
// which accepts key_in as round key NR and skips the forward expansion.
module aes_inv_key_schedule #(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_LAST = 8'h36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
`ifdef AES_INV_KS_DIRECT_LOAD_EN
  input  logic         load_last,
`endif
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_SUB = 3'd1,
    F_XOR = 3'd2,
    HOLD  = 3'd3,
    B_SUB = 3'd4,
    B_XOR = 3'd5
  } state_t;

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  // AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] msb;
    msb = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[msb -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    logic [8:0] t;
    t = b[0] ? ({1'b0, b} ^ 9'h11b) : {1'b0, b};
    return t[8:1];
  endfunction

  // Key byte k lives at key[8k+7:8k]; word i is {byte 4i, 4i+1, 4i+2, 4i+3}.
  function automatic logic [31:0] load_word(input logic [127:0] key, input int i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = key[8*(4*i+j) +: 8];
    end
    return w;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [3:0]  rnd_q;
  logic [7:0]  rcon_q;
  logic        done_q;
  logic        load_direct;
  logic        next_acc;
  logic [31:0] sbox_in_p0;
  logic [31:0] sub_p1;
  logic [31:0] nw0, fw1, fw2, fw3;

`ifdef AES_INV_KS_DIRECT_LOAD_EN
  assign load_direct = load_last;
`else
  assign load_direct = 1'b0;
`endif

  // next only counts while a key is on display.
  assign next_acc = (state_q == HOLD) && next;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = load_direct ? HOLD : F_SUB;
      F_SUB:   state_d = F_XOR;
      F_XOR:   state_d = (rnd_q == NR_M1) ? HOLD : F_SUB;
      HOLD:    if (next) state_d = (rnd_q == 4'd0) ? IDLE : B_SUB;
      B_SUB:   state_d = B_XOR;
      B_XOR:   state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: word presented to the S-box (rotated W3, or rotated W3^W2 going backward).
  always_comb begin
    sbox_in_p0 = (state_q == B_SUB) ? rot_word(w3_q ^ w2_q) : rot_word(w3_q);
  end

  // Stage p1: registered S-box output.
  always_ff @(posedge clk) begin
    sub_p1 <= sub_word(sbox_in_p0);
  end

  // Word updates; W0 update is the same in both directions.
  always_comb begin
    nw0 = w0_q ^ sub_p1 ^ {rcon_q, 24'h0};
    fw1 = w1_q ^ nw0;
    fw2 = w2_q ^ fw1;
    fw3 = w3_q ^ fw2;
  end

  // Schedule words, round counter, Rcon and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      w3_q   <= '0;
      rnd_q  <= '0;
      rcon_q <= 8'h01;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            w0_q <= load_word(key_in, 0);
            w1_q <= load_word(key_in, 1);
            w2_q <= load_word(key_in, 2);
            w3_q <= load_word(key_in, 3);
            if (load_direct) begin
              rnd_q  <= NR_L;
              rcon_q <= RCON_LAST;
            end else begin
              rnd_q  <= 4'd0;
              rcon_q <= 8'h01;
            end
          end
        end
        F_XOR: begin
          w0_q  <= nw0;
          w1_q  <= fw1;
          w2_q  <= fw2;
          w3_q  <= fw3;
          rnd_q <= rnd_q + 4'd1;
          // The last forward round keeps its Rcon: it is the first one the
          // backward walk needs.
          if (rnd_q != NR_M1) rcon_q <= xtime(rcon_q);
        end
        HOLD: begin
          if (next_acc && (rnd_q == 4'd0)) done_q <= 1'b1;
        end
        B_XOR: begin
          w3_q   <= w3_q ^ w2_q;
          w2_q   <= w2_q ^ w1_q;
          w1_q   <= w1_q ^ w0_q;
          w0_q   <= nw0;
          rcon_q <= inv_xtime(rcon_q);
          rnd_q  <= rnd_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign round_key = {w3_q, w2_q, w1_q, w0_q};
  assign round_num = rnd_q;
  assign key_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule with a scoreboard of expected round keys.
module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
`ifdef AES_INV_KS_DIRECT_LOAD_EN
  logic         load_last;
`endif
  logic         next;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [3:0]   rn;
    logic [127:0] key;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] exp_key [0:10];
  int           errors;
  int           checks;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
`ifdef AES_INV_KS_DIRECT_LOAD_EN
    .load_last (load_last),
`endif
    .next      (next),
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_num"}, 128'(round_num), 128'(e.rn));
      check({tag, "_key"}, round_key, e.key);
    end
  endtask

  // One backward step: pulse next, expect the key 2 cycles after next is taken.
  task automatic step_back(input int k, input bit hold_next);
    int lat;
    sb_q.push_back('{rn: 4'(k), key: exp_key[k]});
    next = 1'b1;
    tick();
    check("kv_drop", 128'(key_valid), 128'(1'b0));
    if (!hold_next) next = 1'b0;
    lat = 0;
    while (!key_valid && lat < 10) begin
      tick();
      lat++;
    end
    next = 1'b0;
    check("back_latency", 128'(lat), 128'(2));
    pop_check("back_step");
  endtask

  initial begin
    int lat;
    errors = 0;
    checks = 0;
    exp_key[0]  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    exp_key[1]  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    exp_key[2]  = 128'h7359f67f_5935807a_7a96b943_f2c295f2;
    exp_key[3]  = 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
    exp_key[4]  = 128'hdb0bad00_b671253b_a8525b7f_ef44a541;
    exp_key[5]  = 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
    exp_key[6]  = 128'hca0093fd_dbf98641_110b3efd_6d88a37a;
    exp_key[7]  = 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e;
    exp_key[8]  = 128'h7f8d292f_312bf560_b58dbad2_ead27321;
    exp_key[9]  = 128'h575c006e_28d12941_19fadc21_ac7766f3;
    exp_key[10] = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    rst    = 1'b1;
    start  = 1'b0;
    next   = 1'b0;
    key_in = '0;
`ifdef AES_INV_KS_DIRECT_LOAD_EN
    load_last = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset and idle
    check("rst_key",   round_key,            128'h0);
    check("rst_num",   128'(round_num),      128'h0);
    check("rst_valid", 128'(key_valid),      128'h0);
    check("rst_busy",  128'(busy),           128'h0);
    check("rst_done",  128'(done),           128'h0);
    tick();
    tick();
    tick();
    check("idle_hold", {round_key[123:0], key_valid, busy, done, |round_num}, 128'h0);

    // Forward phase, with a stray start in F_XOR and a stray next before key_valid
    key_in = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    start  = 1'b1;
    sb_q.push_back('{rn: 4'd10, key: exp_key[10]});
    tick();
    lat   = 1;
    start = 1'b0;
    check("fwd_busy", 128'(busy), 128'(1'b1));
    tick();
    lat++;
    start  = 1'b1;
    next   = 1'b1;
    key_in = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    tick();
    lat++;
    start = 1'b0;
    tick();
    lat++;
    next = 1'b0;
    while (!key_valid && lat < 60) begin
      tick();
      lat++;
    end
    check("fwd_latency", 128'(lat), 128'(21));
    pop_check("round10");
    tick();
    tick();
    check("hold_valid", 128'(key_valid), 128'(1'b1));
    check("hold_key",   round_key,       exp_key[10]);
    check("hold_busy",  128'(busy),      128'(1'b1));

    // Backward walk; the first two steps keep next high through the step
    for (int k = 9; k >= 0; k--) begin
      step_back(k, k >= 8);
    end

    // Consuming round 0 ends the run
    next = 1'b1;
    tick();
    next = 1'b0;
    check("end_done",  128'(done),      128'(1'b1));
    check("end_busy",  128'(busy),      128'(1'b0));
    check("end_valid", 128'(key_valid), 128'(1'b0));
    check("end_key",   round_key,       exp_key[0]);
    tick();
    check("done_pulse", 128'(done), 128'(1'b0));

    // Reset in the middle of a backward step
    key_in = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    start  = 1'b1;
    sb_q.push_back('{rn: 4'd10, key: exp_key[10]});
    tick();
    start = 1'b0;
    lat   = 1;
    while (!key_valid && lat < 60) begin
      tick();
      lat++;
    end
    pop_check("rerun10");
    next = 1'b1;
    tick();
    next = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_key",   round_key,       128'h0);
    check("arst_num",   128'(round_num), 128'h0);
    check("arst_valid", 128'(key_valid), 128'h0);
    check("arst_busy",  128'(busy),      128'h0);
    check("arst_done",  128'(done),      128'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_busy", 128'(busy), 128'h0);

`ifdef AES_INV_KS_DIRECT_LOAD_EN
    // Direct load of round key NR
    key_in    = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    load_last = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    load_last = 1'b0;
    check("dl_valid", 128'(key_valid), 128'(1'b1));
    check("dl_num",   128'(round_num), 128'(10));
    check("dl_key",   round_key,       exp_key[10]);
    for (int k = 9; k >= 0; k--) begin
      step_back(k, 1'b0);
    end
    check("dl_final", round_key, exp_key[0]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
